// File: rtl/disaster_pkg.sv
// Shared constants and helpers for the disaster warning front end.
// Channel ids, severity level encoding and the hysteresis target rule.
package disaster_pkg;

    localparam int NUM_CH     = 4;
    localparam int CH_RAIN    = 0;
    localparam int CH_SEISMIC = 1;
    localparam int CH_WIND    = 2;
    localparam int CH_LEVEL   = 3;

    typedef enum logic [1:0] {
        LVL_NONE   = 2'b00,
        LVL_LOW    = 2'b01,
        LVL_HIGH   = 2'b10,
        LVL_SEVERE = 2'b11
    } level_t;

    // Rising uses the plain thresholds, falling uses the hysteresis-lowered ones.
    function automatic level_t pick_target(level_t cur, logic [1:0] up, logic [1:0] down);
        if (up > cur) return level_t'(up);
        if (down < cur) return level_t'(down);
        return cur;
    endfunction

endpackage

// File: rtl/sensor_level_quantizer_if.sv
// Time-multiplexed raw sample bus feeding the level quantizer.
interface sensor_level_quantizer_if #(
    parameter int DATA_W = 8
) ();
    logic              sample_valid;
    logic [1:0]        sample_ch;
    logic [DATA_W-1:0] sample_data;

    modport master (output sample_valid, output sample_ch, output sample_data);
    modport slave  (input  sample_valid, input  sample_ch, input  sample_data);
endinterface

// File: rtl/quantizer_channel.sv
// One sensor channel: threshold/hysteresis compare, debounce and stale timer.
// Level and stale outputs are registered.
module quantizer_channel
    import disaster_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TH1      = 64,
    parameter int TH2      = 128,
    parameter int TH3      = 192,
    parameter int HYST     = 8,
    parameter int DEBOUNCE = 3,
    parameter int TIMEOUT  = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output level_t            level,
    output logic              stale
);

    localparam int SW = DATA_W + 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0] UP1 = SW'(TH1);
    localparam logic [SW-1:0] UP2 = SW'(TH2);
    localparam logic [SW-1:0] UP3 = SW'(TH3);
    localparam logic [SW-1:0] DN1 = SW'((TH1 > HYST) ? TH1 - HYST : 0);
    localparam logic [SW-1:0] DN2 = SW'((TH2 > HYST) ? TH2 - HYST : 0);
    localparam logic [SW-1:0] DN3 = SW'((TH3 > HYST) ? TH3 - HYST : 0);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT);

    function automatic logic [1:0] count_ge(logic [SW-1:0] s, logic [SW-1:0] a,
                                            logic [SW-1:0] b, logic [SW-1:0] c);
        return 2'(s >= a) + 2'(s >= b) + 2'(s >= c);
    endfunction

    logic [SW-1:0] sample;
    logic [1:0]    up;
    logic [1:0]    down;
    level_t        target;
    level_t        cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [TW-1:0] idle;

    always_comb begin
        sample = {1'b0, data};
        up     = count_ge(sample, UP1, UP2, UP3);
        down   = count_ge(sample, DN1, DN2, DN3);
        target = pick_target(level, up, down);
        // A new candidate restarts the count at one; a repeat extends it.
        cnt_nx = (target != cand) ? CW'(1) : cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= LVL_NONE;
            cand  <= LVL_NONE;
            cnt   <= '0;
        end else if (en) begin
            if (target == level) begin
                cnt <= '0;
            end else begin
                cand <= target;
                if (cnt_nx == DB_LAST) begin
                    level <= target;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt_nx;
                end
            end
        end
    end

    // Idle timer saturates; stale rises together with the counter reaching the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle  <= '0;
            stale <= 1'b0;
        end else if (en) begin
            idle  <= '0;
            stale <= 1'b0;
        end else if (idle != TO_LAST) begin
            idle <= idle + TW'(1);
            if (idle + TW'(1) == TO_LAST) stale <= 1'b1;
        end
    end

endmodule

// File: rtl/sensor_level_quantizer.sv
// Four-channel sensor front end: routes samples to per-channel quantizers and
// maps their debounced levels onto the classifier input pins.
module sensor_level_quantizer
    import disaster_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TH1      = 64,
    parameter int TH2      = 128,
    parameter int TH3      = 192,
    parameter int HYST     = 8,
    parameter int DEBOUNCE = 3,
    parameter int TIMEOUT  = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    sensor_level_quantizer_if.slave  smp,
    output logic                     r1,
    output logic                     r0,
    output logic                     s1,
    output logic                     s0,
    output logic                     w1,
    output logic                     w0,
    output logic                     l1,
    output logic                     l0,
    output logic [NUM_CH-1:0]        stale,
    output logic                     levels_ready
);

    level_t             level [NUM_CH];
    logic [NUM_CH-1:0]  en;
    logic [NUM_CH-1:0]  seen;

    always_comb begin
        en = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            en[i] = smp.sample_valid && (smp.sample_ch == 2'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        quantizer_channel #(
            .DATA_W   (DATA_W),
            .TH1      (TH1),
            .TH2      (TH2),
            .TH3      (TH3),
            .HYST     (HYST),
            .DEBOUNCE (DEBOUNCE),
            .TIMEOUT  (TIMEOUT)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .en    (en[g]),
            .data  (smp.sample_data),
            .level (level[g]),
            .stale (stale[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen <= '0;
        end else begin
            seen <= seen | en;
        end
    end

    assign levels_ready = &seen;
    assign {r1, r0} = level[CH_RAIN];
    assign {s1, s0} = level[CH_SEISMIC];
    assign {w1, w0} = level[CH_WIND];
    assign {l1, l0} = level[CH_LEVEL];

endmodule

// File: tb/tb_sensor_level_quantizer.sv
// Directed and randomized checks of sensor_level_quantizer against a behavioural model.
module tb_sensor_level_quantizer;

    localparam int DATA_W   = 8;
    localparam int HYST     = 8;
    localparam int DEBOUNCE = 3;
    localparam int TIMEOUT  = 1000;
    localparam int TH [3]   = '{64, 128, 192};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic r1, r0, s1, s0, w1, w0, l1, l0;
    logic [3:0] stale;
    logic levels_ready;
    logic [7:0] lv;

    int total = 0;
    int bad   = 0;

    int m_lvl [4];
    int m_cand[4];
    int m_run [4];
    int m_idle[4];
    bit m_seen[4];
    int cur   [4];
    int vals  [14] = '{0, 55, 56, 63, 64, 119, 120, 127, 128, 183, 184, 191, 192, 255};

    sensor_level_quantizer_if #(.DATA_W(DATA_W)) bus ();

    sensor_level_quantizer #(
        .DATA_W(DATA_W), .TH1(64), .TH2(128), .TH3(192),
        .HYST(HYST), .DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .smp(bus.slave),
        .r1(r1), .r0(r0), .s1(s1), .s0(s0), .w1(w1), .w0(w0), .l1(l1), .l0(l0),
        .stale(stale), .levels_ready(levels_ready)
    );

    always #5 clk = ~clk;
    assign lv = {r1, r0, s1, s0, w1, w0, l1, l0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: level from counting thresholds, commit after DEBOUNCE same-target samples in a row.
    task automatic model_edge(input bit r, input bit v, input int c, input int d);
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_lvl[i] = 0; m_cand[i] = 0; m_run[i] = 0; m_idle[i] = 0; m_seen[i] = 0;
            end
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (v && c == i) begin
                int up, dn, tgt, lo;
                up = 0; dn = 0;
                for (int k = 0; k < 3; k++) begin
                    lo = (TH[k] > HYST) ? TH[k] - HYST : 0;
                    if (d >= TH[k]) up++;
                    if (d >= lo) dn++;
                end
                if (up > m_lvl[i]) tgt = up;
                else if (dn < m_lvl[i]) tgt = dn;
                else tgt = m_lvl[i];
                if (tgt == m_lvl[i]) begin
                    m_run[i] = 0;
                end else begin
                    if (m_run[i] > 0 && tgt == m_cand[i]) m_run[i]++;
                    else begin m_cand[i] = tgt; m_run[i] = 1; end
                    if (m_run[i] >= DEBOUNCE) begin m_lvl[i] = tgt; m_run[i] = 0; end
                end
                m_idle[i] = 0;
                m_seen[i] = 1;
            end else if (m_idle[i] < TIMEOUT) begin
                m_idle[i]++;
            end
        end
    endtask

    task automatic tick(input bit r, input bit v, input int c, input int d);
        logic [7:0] exp_lv;
        logic [3:0] exp_st;
        rst = r;
        bus.sample_valid = v;
        bus.sample_ch    = 2'(c);
        bus.sample_data  = 8'(d);
        @(posedge clk);
        model_edge(r, v, c, d);
        #1;
        exp_lv = {2'(m_lvl[0]), 2'(m_lvl[1]), 2'(m_lvl[2]), 2'(m_lvl[3])};
        for (int i = 0; i < 4; i++) exp_st[i] = (m_idle[i] >= TIMEOUT);
        check("model_levels", lv, exp_lv);
        check("model_stale", stale, exp_st);
        check("model_ready", levels_ready, m_seen[0] & m_seen[1] & m_seen[2] & m_seen[3]);
    endtask

    initial begin
        int ch, mute;
        bus.sample_valid = 1'b0;
        bus.sample_ch    = 2'd0;
        bus.sample_data  = '0;

        tick(1, 0, 0, 0);
        tick(1, 1, 0, 200);
        check("reset_levels", lv, 8'h00);
        check("reset_stale", stale, 4'h0);
        check("reset_ready", levels_ready, 1'b0);

        tick(0, 1, 0, 130);
        tick(0, 1, 0, 130);
        check("rain_two_samples", lv, 8'h00);
        tick(0, 1, 0, 130);
        check("rain_third_sample", lv, 8'h80);
        check("ready_only_rain", levels_ready, 1'b0);

        for (int i = 0; i < 3; i++) tick(0, 1, 0, 125);
        check("hyst_hold_125", lv, 8'h80);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 119);
        check("hyst_drop_119", lv, 8'h40);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 200);
        check("jump_to_severe", lv, 8'hC0);

        tick(0, 1, 2, 130);
        tick(0, 1, 2, 130);
        tick(0, 1, 2, 70);
        tick(0, 1, 2, 130);
        tick(0, 1, 2, 130);
        check("wind_restart_pending", lv, 8'hC0);
        tick(0, 1, 2, 130);
        check("wind_commit", lv, 8'hC8);

        tick(0, 1, 1, 200);
        check("ready_before_ch3", levels_ready, 1'b0);
        tick(0, 1, 3, 200);
        check("ready_all_seen", levels_ready, 1'b1);
        tick(0, 1, 1, 200);
        tick(0, 1, 3, 200);
        tick(0, 1, 1, 200);
        check("seismic_commit", lv, 8'hF8);
        tick(0, 1, 3, 200);
        check("interleave_levels", lv, 8'hFB);

        for (int i = 0; i < TIMEOUT - 1; i++) tick(0, 0, 0, 0);
        check("stale3_before_limit", stale[3], 1'b0);
        tick(0, 0, 0, 0);
        check("stale3_at_limit", stale[3], 1'b1);
        check("levels_held_stale", lv, 8'hFB);
        tick(0, 1, 3, 200);
        check("stale3_cleared", stale[3], 1'b0);

        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        check("rain_pending_drop", lv, 8'hFB);
        tick(1, 1, 0, 0);
        check("mid_reset_levels", lv, 8'h00);
        check("mid_reset_stale", stale, 4'h0);
        check("mid_reset_ready", levels_ready, 1'b0);
        tick(0, 1, 0, 130);
        tick(0, 1, 0, 130);
        check("post_reset_two", lv, 8'h00);
        tick(0, 1, 0, 130);
        check("post_reset_three", lv, 8'h80);

        for (int i = 0; i < 4; i++) cur[i] = vals[$urandom_range(13)];
        for (int n = 0; n < 1500; n++) begin
            ch = $urandom_range(3);
            if ($urandom_range(5) == 0) cur[ch] = ($urandom_range(1) == 0) ? vals[$urandom_range(13)]
                                                                          : int'($urandom_range(255));
            tick($urandom_range(299) == 0, $urandom_range(3) != 0, ch, cur[ch]);
        end
        mute = 1;
        for (int n = 0; n < 1200; n++) begin
            ch = $urandom_range(3);
            if (ch == mute) ch = 0;
            if ($urandom_range(5) == 0) cur[ch] = vals[$urandom_range(13)];
            tick(0, $urandom_range(3) != 0, ch, cur[ch]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
